match_event_reporter: RTL and testbench

- Sits directly downstream of decoder1024 and consumes its single-bit `out` (pattern-match) signal.
- Turns match assertions into discrete timestamped events: rising-edge detection, programmable holdoff, saturating match counter, small event FIFO drained over a valid/ready handshake.
- Lets the host log each detection of the programmed 1024-bit pattern without sampling the comparator every cycle.

---
 rtl/match_event_reporter.sv | 102 ++++++++++
 tb/tb_match_event_reporter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/match_event_reporter.sv
// Turns the decoder1024 match level into timestamped events: rising-edge detect,
// holdoff window, saturating event counter and a small event FIFO with valid/ready drain.
module match_event_reporter #(
  parameter int TS_W    = 16,
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             match_in,
  input  logic             arm,
  input  logic             clear_ovf,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [TS_W-1:0]  out_ts,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              match_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic rise, accept, pop, full, push, drop;

  always_comb begin
    rise     = match_in & ~match_q;
    accept   = rise & arm & (hold_q == '0);
    full     = (occ_q == OCC_W'(DEPTH));
    pop      = (occ_q != '0) & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push     = accept & (~full | pop);
    drop     = accept & full & ~pop;

    ts_d     = ts_q + TS_W'(1);
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (accept) begin
      hold_d = HOLD_W'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ts_q     <= '0;
      match_q  <= 1'b0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      match_q  <= match_in;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: out_ts is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!clr && push) mem_q[wr_ptr_q] <= ts_q;
  end

  assign out_valid   = (occ_q != '0);
  assign out_ts      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_event_reporter.sv
// Bench for match_event_reporter: two instances (HOLDOFF=8 and HOLDOFF=0) on shared inputs,
// a fixed vector table, directed corner sequences and random traffic against a queue model.
module tb_match_event_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, match_in, arm, clear_ovf, out_ready;
  logic        ov   [2];
  logic        vld  [2];
  logic [15:0] ots  [2];
  logic [7:0]  cnt  [2];

  match_event_reporter #(.TS_W(16), .CNT_W(8), .DEPTH(4), .HOLDOFF(8)) u_dut_h8 (
    .clk(clk), .clr(clr), .match_in(match_in), .arm(arm), .clear_ovf(clear_ovf),
    .out_ready(out_ready), .out_valid(vld[0]), .out_ts(ots[0]),
    .match_count(cnt[0]), .overflow(ov[0])
  );

  match_event_reporter #(.TS_W(16), .CNT_W(8), .DEPTH(4), .HOLDOFF(0)) u_dut_h0 (
    .clk(clk), .clr(clr), .match_in(match_in), .arm(arm), .clear_ovf(clear_ovf),
    .out_ready(out_ready), .out_valid(vld[1]), .out_ts(ots[1]),
    .match_count(cnt[1]), .overflow(ov[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: events are timestamps in a queue; holdoff is "edges since last accept".
  int m_ts   [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_last [2] = '{-1000000, -1000000};
  bit m_prev [2] = '{1'b0, 1'b0};
  bit m_ovf  [2] = '{1'b0, 1'b0};
  int mq     [2][$];
  int m_edge = 0;

  function automatic int hold_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  task automatic model_step(input int k);
    bit acc;
    if (clr) begin
      m_ts[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_prev[k] = 1'b0;
      m_last[k] = -1000000;
      mq[k].delete();
    end else begin
      acc = match_in && !m_prev[k] && arm && ((m_edge - m_last[k]) > hold_of(k));
      if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
      if (clear_ovf) m_ovf[k] = 1'b0;
      if (acc) begin
        m_last[k] = m_edge;
        if (m_cnt[k] < 255) m_cnt[k]++;
        if (mq[k].size() < 4) mq[k].push_back(m_ts[k]);
        else m_ovf[k] = 1'b1;
      end
      m_prev[k] = match_in;
      m_ts[k]   = (m_ts[k] + 1) % 65536;
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model[%0d].out_valid", k), int'(vld[k]), int'(mq[k].size() > 0));
      chk($sformatf("model[%0d].out_ts", k), int'(ots[k]), (mq[k].size() > 0) ? mq[k][0] : 0);
      chk($sformatf("model[%0d].match_count", k), int'(cnt[k]), m_cnt[k]);
      chk($sformatf("model[%0d].overflow", k), int'(ov[k]), int'(m_ovf[k]));
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit c, input bit m, input bit a, input bit co, input bit r);
    clr = c; match_in = m; arm = a; clear_ovf = co; out_ready = r;
    for (int k = 0; k < 2; k++) model_step(k);
    m_edge++;
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit c, m, a, co, r;
    bit ev;
    int ets;
    int ecnt;
    bit eovf;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input bit c, input bit m, input bit r,
                              input bit ev, input int ets, input int ecnt);
    vec_t v;
    v.c = c; v.m = m; v.a = 1'b1; v.co = 1'b0; v.r = r;
    v.ev = ev; v.ets = ets; v.ecnt = ecnt; v.eovf = 1'b0;
    return v;
  endfunction

  initial begin
    clr = 1'b1; match_in = 1'b0; arm = 1'b1; clear_ovf = 1'b0; out_ready = 1'b0;

    // Table for the HOLDOFF=8 instance: entry n (n>=2) samples timestamp n-2.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 5, 1);
    tbl[8]  = mk(0, 1, 0, 1, 5, 1);
    tbl[9]  = mk(0, 1, 0, 1, 5, 1);
    tbl[10] = mk(0, 1, 0, 1, 5, 1);
    tbl[11] = mk(0, 1, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 0, 1);   // rise at ts 11, inside holdoff
    tbl[14] = mk(0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 1);   // rise at ts 13, last blocked edge
    tbl[16] = mk(0, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 1, 15, 2);  // rise at ts 15, accepted
    tbl[18] = mk(0, 0, 1, 0, 0, 2);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].c, tbl[i].m, tbl[i].a, tbl[i].co, tbl[i].r);
      chk($sformatf("tbl[%0d].out_valid", i), int'(vld[0]), int'(tbl[i].ev));
      chk($sformatf("tbl[%0d].out_ts", i), int'(ots[0]), tbl[i].ets);
      chk($sformatf("tbl[%0d].match_count", i), int'(cnt[0]), tbl[i].ecnt);
      chk($sformatf("tbl[%0d].overflow", i), int'(ov[0]), int'(tbl[i].eovf));
    end

    // Idle after reset: timestamp must have reached 20.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
    chk("idle.out_valid", int'(vld[0]), 0);
    chk("idle.match_count", int'(cnt[0]), 0);
    cyc(0, 1, 1, 0, 0);
    chk("idle.ts20", int'(ots[0]), 20);
    cyc(0, 0, 1, 0, 1);
    chk("idle.popped", int'(vld[0]), 0);

    // Holdoff: rises at ts 10, 12, 18, 20.
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 25; i++)
      cyc(0, (i == 10 || i == 12 || i == 18 || i == 20), 1, 0, 0);
    chk("hold.h8.count", int'(cnt[0]), 2);
    chk("hold.h0.count", int'(cnt[1]), 4);
    chk("hold.h8.head", int'(ots[0]), 10);
    chk("hold.h0.ovf", int'(ov[1]), 0);
    cyc(0, 0, 1, 0, 1);
    chk("hold.h8.second", int'(ots[0]), 20);
    chk("hold.h0.second", int'(ots[1]), 12);

    // Overflow: six accepts into a 4-deep FIFO, rises at ts 1, 11, ..., 51.
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 60; i++) cyc(0, (i % 10 == 1), 1, 0, 0);
    chk("ovf.count", int'(cnt[0]), 6);
    chk("ovf.flag", int'(ov[0]), 1);
    chk("ovf.head", int'(ots[0]), 1);
    cyc(0, 0, 1, 1, 0);
    chk("ovf.cleared", int'(ov[0]), 0);
    chk("ovf.head_kept", int'(ots[0]), 1);
    // Full FIFO, accept and pop in the same cycle (ts 61).
    cyc(0, 1, 1, 0, 1);
    chk("full_pp.head", int'(ots[0]), 11);
    chk("full_pp.ovf", int'(ov[0]), 0);
    chk("full_pp.count", int'(cnt[0]), 7);
    cyc(0, 0, 1, 0, 1);
    chk("drain.1", int'(ots[0]), 21);
    cyc(0, 0, 1, 0, 1);
    chk("drain.2", int'(ots[0]), 31);
    cyc(0, 0, 1, 0, 1);
    chk("drain.3", int'(ots[0]), 61);
    cyc(0, 0, 1, 0, 1);
    chk("drain.empty", int'(vld[0]), 0);

    // Arm gating: match already high when arm rises gives no event.
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    chk("arm.valid", int'(vld[0]), 0);
    chk("arm.count", int'(cnt[0]), 0);
    chk("arm.count_h0", int'(cnt[1]), 0);
    for (int i = 0; i < 30; i++) cyc(0, (i % 10 == 5), 1, 0, 0);
    chk("mid.count", int'(cnt[0]), 3);
    chk("mid.valid", int'(vld[0]), 1);
    cyc(1, 0, 1, 0, 0);
    chk("mid.clr_valid", int'(vld[0]), 0);
    chk("mid.clr_count", int'(cnt[0]), 0);
    chk("mid.clr_ts", int'(ots[0]), 0);

    // Saturation: 300 accepts.
    for (int i = 0; i < 3000; i++) cyc(0, (i % 10 == 0), 1, 0, 1);
    chk("sat.h8", int'(cnt[0]), 255);
    chk("sat.h0", int'(cnt[1]), 255);

    // Random traffic against the model.
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 127) == 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
